// File: rtl/debug_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : debug_pipe_ctrl
// Description : Pipeline hold/flush controller for the 5-stage core. Merges
//               the hazard sources (load-use, multi-cycle memory access,
//               taken branch) with debugger run control (halt, resume,
//               single-step) and drives the stall/flush controls that every
//               pipeline stage register obeys.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   system clock
//   reset           in   asynchronous, active-high reset
//   haltreq         in   debugger halt request (level)
//   resumereq       in   debugger resume request (level)
//   stepreq         in   debugger single-step request (level)
//   load_use_hazard in   ID instruction depends on a load in EX
//   mem_busy        in   multi-cycle data access in progress
//   branch_taken    in   redirect resolved in EX
//   stall_front     out  hold for PC and IF/ID
//   stall_back      out  hold for ID/EX, EX/MEM, MEM/WB
//   flush_if_id     out  clear IF/ID
//   flush_id_ex     out  clear ID/EX (bubble insert)
//   halted          out  core halted (registered)
//   resume_ack      out  one-cycle pulse on HALTED -> RUN (registered)
//   drain_cnt       out  remaining drain cycles
// ============================================================================
module debug_pipe_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             haltreq,
    input  logic             resumereq,
    input  logic             stepreq,
    input  logic             load_use_hazard,
    input  logic             mem_busy,
    input  logic             branch_taken,
    output logic             stall_front,
    output logic             stall_back,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halted,
    output logic             resume_ack,
    output logic [CNT_W-1:0] drain_cnt
);

    localparam logic [CNT_W-1:0] c_DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_STEP   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0] w_drain_cnt_nxt;
    logic             r_halted;
    logic             r_resume_ack;
    logic             w_halted_nxt;
    logic             w_resume_ack_nxt;

    // ------------------------------------------------------------------------
    // State and status registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_drain_cnt  <= '0;
            r_halted     <= 1'b0;
            r_resume_ack <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_drain_cnt  <= w_drain_cnt_nxt;
            r_halted     <= w_halted_nxt;
            r_resume_ack <= w_resume_ack_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and zero-latency stall/flush outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_drain_cnt_nxt  = r_drain_cnt;
        w_resume_ack_nxt = 1'b0;
        stall_front      = 1'b0;
        stall_back       = mem_busy;
        flush_if_id      = 1'b0;
        flush_id_ex      = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (branch_taken) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (load_use_hazard) begin
                    stall_front = 1'b1;
                    flush_id_ex = 1'b1;
                end
                // A halt is accepted even while memory is busy; the drain
                // counter simply does not move until the access completes.
                if (haltreq) begin
                    w_state_nxt     = ST_DRAIN;
                    w_drain_cnt_nxt = c_DRAIN_LOAD;
                end
            end

            ST_DRAIN: begin
                // Hold the IF/ID instruction unissued, but let a branch in
                // EX redirect the PC so the halt PC is architecturally right.
                stall_front = ~branch_taken;
                flush_if_id = branch_taken;
                flush_id_ex = 1'b1;
                if (!mem_busy) begin
                    w_drain_cnt_nxt = r_drain_cnt - c_CNT_ONE;
                    if (r_drain_cnt == c_CNT_ONE) begin
                        w_state_nxt = ST_HALTED;
                    end
                end
            end

            ST_HALTED: begin
                stall_front = 1'b1;
                flush_id_ex = 1'b1;
                if (!mem_busy) begin
                    if (resumereq) begin
                        w_state_nxt      = ST_RUN;
                        w_resume_ack_nxt = 1'b1;
                    end else if (stepreq) begin
                        w_state_nxt = ST_STEP;
                    end
                end
            end

            ST_STEP: begin
                // Release the front end for exactly one issue slot.
                if (!mem_busy) begin
                    w_state_nxt     = ST_DRAIN;
                    w_drain_cnt_nxt = c_DRAIN_LOAD;
                end
            end

            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        // A busy memory access freezes the whole pipe: nothing may be
        // flushed underneath an outstanding access.
        if (mem_busy) begin
            stall_front = 1'b1;
            flush_if_id = 1'b0;
            flush_id_ex = 1'b0;
        end
    end

    // halted rises one cycle after entering HALTED and falls on the cycle
    // the FSM leaves it, together with resume_ack.
    assign w_halted_nxt = (r_state == ST_HALTED) && (w_state_nxt == ST_HALTED);

    assign halted     = r_halted;
    assign resume_ack = r_resume_ack;
    assign drain_cnt  = r_drain_cnt;

endmodule
`default_nettype wire

// File: tb/tb_debug_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_pipe_ctrl
// Description : Self-checking bench for debug_pipe_ctrl. Directed scenarios
//               followed by randomized traffic, all compared against a
//               behavioural model of the run-control rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_pipe_ctrl;

    localparam int DRAIN = 3;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          haltreq, resumereq, stepreq;
    logic          load_use_hazard, mem_busy, branch_taken;
    logic          stall_front, stall_back, flush_if_id, flush_id_ex;
    logic          halted, resume_ack;
    logic [CW-1:0] drain_cnt;

    debug_pipe_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .haltreq         (haltreq),
        .resumereq       (resumereq),
        .stepreq         (stepreq),
        .load_use_hazard (load_use_hazard),
        .mem_busy        (mem_busy),
        .branch_taken    (branch_taken),
        .stall_front     (stall_front),
        .stall_back      (stall_back),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .halted          (halted),
        .resume_ack      (resume_ack),
        .drain_cnt       (drain_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: what the core is doing, in debugger terms.
    int m_left;       // pipeline drain cycles still outstanding (0 = none)
    bit m_in_halt;    // core is parked in debug halt
    bit m_stepping;   // single issue slot granted this cycle
    bit m_halted_o;
    bit m_ack_o;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_left = 0; m_in_halt = 0; m_stepping = 0; m_halted_o = 0; m_ack_o = 0;
    endtask

    task automatic check_outputs(input string tag);
        bit e_sf, e_fi, e_fe;
        e_sf = 0; e_fi = 0; e_fe = 0;
        if (mem_busy) begin
            e_sf = 1;
        end else if (m_stepping) begin
            e_sf = 0;
        end else if (m_in_halt) begin
            e_sf = 1; e_fe = 1;
        end else if (m_left > 0) begin
            e_fi = branch_taken; e_sf = !branch_taken; e_fe = 1;
        end else if (branch_taken) begin
            e_fi = 1; e_fe = 1;
        end else if (load_use_hazard) begin
            e_sf = 1; e_fe = 1;
        end
        chk({tag, ".stall_front"}, 8'(stall_front), 8'(e_sf));
        chk({tag, ".stall_back"},  8'(stall_back),  8'(mem_busy));
        chk({tag, ".flush_if_id"}, 8'(flush_if_id), 8'(e_fi));
        chk({tag, ".flush_id_ex"}, 8'(flush_id_ex), 8'(e_fe));
        chk({tag, ".halted"},      8'(halted),      8'(m_halted_o));
        chk({tag, ".resume_ack"},  8'(resume_ack),  8'(m_ack_o));
        chk({tag, ".drain_cnt"},   8'(drain_cnt),   8'(m_left));
    endtask

    task automatic model_clock();
        bit was_halt, ack;
        was_halt = m_in_halt;
        ack = 0;
        if (m_stepping) begin
            if (!mem_busy) begin m_stepping = 0; m_left = DRAIN; end
        end else if (m_in_halt) begin
            if (!mem_busy) begin
                if (resumereq) begin m_in_halt = 0; ack = 1; end
                else if (stepreq) begin m_in_halt = 0; m_stepping = 1; end
            end
        end else if (m_left > 0) begin
            if (!mem_busy) begin
                m_left--;
                if (m_left == 0) m_in_halt = 1;
            end
        end else if (haltreq) begin
            m_left = DRAIN;
        end
        m_halted_o = was_halt && m_in_halt;
        m_ack_o = ack;
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic cyc(input string tag, input bit hr, input bit rr, input bit sr,
                       input bit lu, input bit mb, input bit br);
        haltreq = hr; resumereq = rr; stepreq = sr;
        load_use_hazard = lu; mem_busy = mb; branch_taken = br;
        @(negedge clk);
        check_outputs(tag);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        haltreq = 0; resumereq = 0; stepreq = 0;
        load_use_hazard = 0; mem_busy = 0; branch_taken = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        reset = 1'b0;

        // Hazards in RUN
        cyc("run_idle", 0, 0, 0, 0, 0, 0);
        cyc("run_lu",   0, 0, 0, 1, 0, 0);
        cyc("run_lu_off", 0, 0, 0, 0, 0, 0);
        cyc("run_lu_br", 0, 0, 0, 1, 0, 1);
        cyc("run_busy", 0, 0, 0, 1, 1, 1);

        // Reset mid-DRAIN with drain_cnt = 2
        cyc("pre_rst0", 1, 0, 0, 0, 0, 0);
        cyc("pre_rst1", 1, 0, 0, 0, 0, 0);
        chk("rst_mid_cnt_before", 8'(drain_cnt), 8'd2);
        haltreq = 0;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_mid_cnt", 8'(drain_cnt), 8'd0);
        chk("rst_mid_sf",  8'(stall_front), 8'd0);
        check_outputs("rst_mid");
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Halt with no memory activity: DRAIN 3,2,1 then HALTED, halted later
        cyc("halt_c0", 1, 0, 0, 0, 0, 0);
        chk("halt_c1_cnt", 8'(drain_cnt), 8'd3);
        cyc("halt_c1", 1, 0, 0, 0, 0, 0);
        chk("halt_c2_cnt", 8'(drain_cnt), 8'd2);
        cyc("halt_c2", 1, 1, 1, 0, 0, 1);
        chk("halt_c3_cnt", 8'(drain_cnt), 8'd1);
        cyc("halt_c3", 1, 0, 0, 0, 0, 0);
        chk("halt_c4_halted", 8'(halted), 8'd0);
        cyc("halt_c4", 1, 0, 0, 0, 0, 0);
        chk("halt_c5_halted", 8'(halted), 8'd1);
        cyc("halt_c5", 1, 0, 0, 0, 0, 0);

        // Single step from HALTED
        cyc("step_req",  0, 0, 1, 0, 0, 0);
        chk("step_sf",   8'(stall_front), 8'd0);
        chk("step_fe",   8'(flush_id_ex), 8'd0);
        chk("step_halt", 8'(halted), 8'd0);
        cyc("step_slot", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("step_drain", 0, 0, 0, 0, 0, 0);
        chk("step_rehalt", 8'(halted), 8'd1);

        // Resume and step together: resume wins
        cyc("resume_req", 0, 1, 1, 0, 0, 0);
        chk("resume_ack1", 8'(resume_ack), 8'd1);
        chk("resume_sf",   8'(stall_front), 8'd0);
        cyc("resume_run",  0, 0, 0, 0, 0, 0);
        chk("resume_ack2", 8'(resume_ack), 8'd0);

        // Halt with mem_busy on cycles 2-4: halted three cycles later
        cyc("hb_c0", 1, 0, 0, 0, 0, 0);
        cyc("hb_c1", 1, 0, 0, 0, 0, 0);
        for (int c = 2; c <= 4; c++) begin
            chk("hb_frozen", 8'(drain_cnt), 8'd2);
            cyc("hb_busy", 1, 0, 0, 0, 1, 0);
        end
        chk("hb_c5_cnt", 8'(drain_cnt), 8'd2);
        cyc("hb_c5", 1, 0, 0, 0, 0, 0);
        cyc("hb_c6", 1, 0, 0, 0, 0, 0);
        cyc("hb_c7", 1, 0, 0, 0, 0, 0);
        chk("hb_c8_halted", 8'(halted), 8'd1);
        cyc("hb_res", 0, 1, 0, 0, 0, 0);
        cyc("hb_run", 0, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            cyc("rand",
                ($urandom % 8) == 0, ($urandom % 6) == 0, ($urandom % 5) == 0,
                ($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debug_pipe_ctrl.md
Name: debug_pipe_ctrl

Overview:
- Generates the hold (Stall) and flush (reset_stages) controls consumed by every pipeline stage register in the 5-stage core.
- Merges the hazard sources (load-use, multi-cycle memory, taken branch) with the external-debugger run-control requests (halt, resume, single-step).
- Sits between the debug module interface and the pipeline stage registers; it is the controlling end of the stall/flush interface those registers obey.

Parameters:
- DRAIN_CYCLES, 3, cycles needed to empty the ID/EX, EX/MEM and MEM/WB registers after issue stops.
- CNT_W, 2, width of the drain counter; must satisfy 2^CNT_W > DRAIN_CYCLES.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- haltreq  input  1  debugger halt request, level.
- resumereq  input  1  debugger resume request, level.
- stepreq  input  1  debugger single-step request, level.
- load_use_hazard  input  1  ID instruction depends on a load in EX.
- mem_busy  input  1  multi-cycle data access in progress.
- branch_taken  input  1  redirect resolved in EX.
- stall_front  output  1  Stall for the PC and IF/ID registers.
- stall_back  output  1  Stall for the ID/EX, EX/MEM and MEM/WB registers.
- flush_if_id  output  1  reset_stages for the IF/ID register.
- flush_id_ex  output  1  reset_stages for the ID/EX register (bubble insert).
- halted  output  1  core halted; registered.
- resume_ack  output  1  one-cycle pulse on leaving HALTED for RUN; registered.
- drain_cnt  output  CNT_W  remaining drain cycles, for debug visibility.

Behaviour:
- FSM states: RUN, DRAIN, HALTED, STEP. Async reset forces RUN, drain_cnt=0, halted=0, resume_ack=0. Reset mid-DRAIN or mid-STEP returns to RUN with no residual stall.
- stall_front, stall_back, flush_if_id and flush_id_ex are combinational from the current state and the hazard inputs, with zero-cycle latency. In all states stall_back=mem_busy.
- When mem_busy=1: stall_front=1, both flushes=0, drain_cnt frozen and FSM transitions inhibited. The exception is haltreq in RUN, which is still accepted.
- RUN:
  - branch_taken: flush_if_id=1, flush_id_ex=1, stall_front=0.
  - else load_use_hazard: stall_front=1, flush_id_ex=1.
  - haltreq=1: next state DRAIN, drain_cnt loads DRAIN_CYCLES. Hazard outputs in that cycle follow the RUN rules.
- DRAIN:
  - stall_front=1, flush_id_ex=1, so the IF/ID instruction is held unissued.
  - drain_cnt decrements on each cycle with mem_busy=0. The cycle it decrements from 1 to 0 transitions to HALTED.
  - branch_taken during DRAIN: flush_if_id=1 and stall_front=0 for that cycle only, so the PC accepts the redirect. drain_cnt is unaffected.
- HALTED:
  - halted=1 (registered, asserted the cycle after entry). stall_front=1, flush_id_ex=1. haltreq is ignored.
  - resumereq has priority over stepreq. resumereq: next state RUN, resume_ack=1 for exactly the following cycle, halted deasserts the same cycle.
  - stepreq: next state STEP, halted deasserts.
- STEP (one cycle):
  - stall_front=0, flush_id_ex=0, so exactly one instruction issues.
  - Next state DRAIN with drain_cnt=DRAIN_CYCLES, ending back in HALTED.
  - If mem_busy holds in STEP, the FSM stays in STEP and stall_front=1.
- resumereq and stepreq in RUN or DRAIN are ignored. Simultaneous haltreq and resumereq in RUN enter DRAIN.
- No level request is latched. The debugger must hold a request until it sees halted (or resume_ack) change.

Test Plan:
- Reset asserted mid-DRAIN (drain_cnt=2) -> RUN immediately; all outputs 0, drain_cnt=0.
- RUN, load_use_hazard=1 for 1 cycle -> stall_front=1 and flush_id_ex=1 that cycle only. With branch_taken=1 in the same cycle -> flush_if_id=1, flush_id_ex=1, stall_front=0.
- haltreq rises at cycle 0, no mem_busy -> DRAIN cycles 1-3 with drain_cnt 3,2,1; HALTED at cycle 4; halted=1 at cycle 5.
- haltreq with mem_busy=1 for cycles 2-4 -> drain_cnt frozen at 2 during busy cycles; halted observed 3 cycles later than in the previous scenario.
- HALTED, stepreq=1 -> one cycle with stall_front=0, flush_id_ex=0, then 3 DRAIN cycles, then halted=1 again.
- HALTED, resumereq and stepreq both 1 -> RUN; resume_ack=1 for exactly 1 cycle; stall_front=0.
